// File: rtl/adder_pkg.sv
// Shared definitions for the adder family (ripple, lookahead, prefix-tree).
//   ADDER_DEFAULT_WIDTH : default operand/sum width.
//   adder_ref_sum()     : behavioural (width+1)-bit reference sum, for
//                         self-checkers and benches only. Operands are passed
//                         zero-extended to 64 bits, so it covers widths <= 64.
package adder_pkg;

  localparam int unsigned ADDER_DEFAULT_WIDTH = 4;

  function automatic logic [64:0] adder_ref_sum(input logic [63:0] a,
                                                input logic [63:0] b,
                                                input logic        cin);
    return {1'b0, a} + {1'b0, b} + {64'd0, cin};
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell, purely combinational.
// Ports:
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// Parameterised unsigned ripple-carry adder with a registered result
// (one-cycle latency, one operation per cycle, no backpressure).
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : a, b, cin valid this cycle
//   a, b      : unsigned addends [width-1:0]
//   cin       : carry in
//   sum       : registered (a + b + cin) mod 2^width
//   cout      : registered carry out of the MSB cell
//   out_valid : sum/cout hold a new result this cycle
// Optional macro ADDER_SELF_CHECK_EN adds a simulation-only checker that
// compares each result against adder_ref_sum() and prints "error occur!"
// on a mismatch. It has no effect on outputs, timing or ports.
module ripple_carry_adder
  import adder_pkg::*;
#(
  parameter int unsigned width = ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             cin,
  output logic [width-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  logic [width:0]   c;
  logic [width-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < width; i++) begin : g_cell
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Result registers only load on in_valid, so X on idle inputs never
  // reaches sum/cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= c[width];
      end
    end
  end

`ifdef ADDER_SELF_CHECK_EN
  logic [width-1:0] chk_a;
  logic [width-1:0] chk_b;
  logic             chk_cin;
  logic [64:0]      chk_ref;

  always_ff @(posedge clk) begin
    if (in_valid) begin
      chk_a   <= a;
      chk_b   <= b;
      chk_cin <= cin;
    end
  end

  assign chk_ref = adder_ref_sum(64'(chk_a), 64'(chk_b), chk_cin);

  // Sampled mid-cycle so the registered result has settled.
  always @(negedge clk) begin
    if (rst_n && out_valid && ({cout, sum} !== chk_ref[width:0]))
      $display("a=%0d b=%0d error occur!", chk_a, chk_b);
  end
`else
  // Checker absent: no simulation-only logic or printing.
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
module tb_ripple_carry_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: what the registered outputs must show.
  logic [W-1:0] exp_sum = '0;
  logic         exp_cout = 1'b0;
  logic         exp_valid = 1'b0;

  ripple_carry_adder #(.width(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Model: reset clears everything at once; each accepted operation's
  // exact integer sum appears after the next edge; idle cycles keep the last result.
  always @(posedge clk or negedge rst_n) begin
    int total;
    if (!rst_n) begin
      exp_sum   = '0;
      exp_cout  = 1'b0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = in_valid;
      if (in_valid) begin
        total     = int'(a) + int'(b) + int'(cin);
        exp_sum   = W'(total % (1 << W));
        exp_cout  = (total >= (1 << W));
      end
    end
  end

  // Compare process, mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("sum", 32'(sum), 32'(exp_sum));
      check("cout", 32'(cout), 32'(exp_cout));
    end
  end

  // Inputs change 2 time units after a rising edge.
  task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc);
    @(posedge clk);
    #2;
    in_valid = v;
    a        = ta;
    b        = tb_;
    cin      = tc;
  endtask

  // Wait for the capture edge of the last drive, then pin DUT and model.
  task automatic expect_lit(input string name, input logic [W-1:0] s_req,
                            input logic c_req, input logic v_req);
    @(posedge clk);
    #1;
    check({name, "_sum"}, 32'(sum), 32'(s_req));
    check({name, "_cout"}, 32'(cout), 32'(c_req));
    check({name, "_valid"}, 32'(out_valid), 32'(v_req));
    check({name, "_model"}, 32'({exp_cout, exp_sum}), 32'({c_req, s_req}));
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    #2;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Exhaustive sweep, cin = 0, back-to-back.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        drive(1'b1, W'(i), W'(j), 1'b0);

    // Carry chain and wrap-around.
    drive(1'b1, 4'd15, 4'd15, 1'b1);
    expect_lit("cc_15_15_1", 4'd15, 1'b1, 1'b1);
    drive(1'b1, 4'd15, 4'd0, 1'b1);
    expect_lit("cc_15_0_1", 4'd0, 1'b1, 1'b1);
    drive(1'b1, 4'd15, 4'd1, 1'b0);
    expect_lit("wrap_15_1", 4'd0, 1'b1, 1'b1);

    // Hold behaviour.
    drive(1'b1, 4'd3, 4'd4, 1'b0);
    drive(1'b0, 4'd9, 4'd9, 1'b0);
    expect_lit("hold", 4'd7, 1'b0, 1'b0);
    drive(1'b0, 4'd9, 4'd9, 1'b1);
    expect_lit("hold2", 4'd7, 1'b0, 1'b0);

    // Randomized traffic with idle gaps.
    for (int k = 0; k < 300; k++)
      drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom));

    // Asynchronous reset between edges.
    drive(1'b1, 4'd8, 4'd8, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_sum", 32'(sum), 32'd0);
    check("areset_cout", 32'(cout), 32'd0);
    check("areset_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 4'd1, 4'd2, 1'b0);
    expect_lit("post_reset", 4'd3, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder.md
Name: ripple_carry_adder

Overview:
- Parameterised unsigned ripple-carry adder: a chain of width full-adder cells, the bit-i carry feeding bit i+1.
- Result captured in an output register, giving one-cycle latency.
- Serves as the reference and low-area member of the adder family; carry-lookahead and prefix-tree variants must match it bit-for-bit.

Parameters:
- width, 4, operand and sum bit width; legal range is 1 or more.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a, b and cin are valid this cycle.
- a  input  width  addend, unsigned.
- b  input  width  addend, unsigned.
- cin  input  1  carry-in.
- sum  output  width  registered (a + b + cin) mod 2^width.
- cout  output  1  registered carry out of the MSB cell.
- out_valid  output  1  sum and cout hold a new result this cycle.

Behaviour:
- Reset: while rst_n is low, sum = 0, cout = 0 and out_valid = 0, immediately and regardless of clk.
- Reset mid-operation: the in-flight result is discarded. The first result after release comes from the first in_valid seen at a clk edge after rst_n goes high.
- Combinational core:
  - c[0] = cin.
  - s[i] = a[i] ^ b[i] ^ c[i].
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])).
  - cout_comb = c[width].
- The core is built structurally from full-adder cells. No "+" operator is used in synthesised logic.
- Timing: on each clk rising edge with rst_n high:
  - out_valid <= in_valid.
  - If in_valid = 1: sum <= s and cout <= cout_comb.
  - If in_valid = 0: sum and cout hold their previous values.
- Latency: exactly 1 cycle from an input edge to its registered result.
- Throughput: one operation per cycle. There is no backpressure and no stall input.
- Arithmetic is unsigned only; there is no overflow flag.
  - {cout, sum} always equals a + b + cin exactly, as a width+1-bit value.
- Wrap-around (width = 4):
  - a = 15, b = 1, cin = 0 gives sum = 0, cout = 1.
  - The full ripple path, all propagate bits set with cin = 1, must settle within one clk period.
- Unknown inputs: if in_valid = 0, X on a, b or cin must not reach sum or cout.

Optional Feature:
- Macro: ADDER_SELF_CHECK_EN.
- Defined: a simulation-only checker runs on every cycle where out_valid = 1.
  - It compares {cout, sum} with the behavioural a + b + cin captured in the previous cycle.
  - On mismatch it prints a message containing the a and b values followed by "error occur!".
  - It does not alter outputs, timing or ports.
- Not defined: the checker is absent and there is no simulation printing.
- Synthesis result is identical either way.

Decomposition:
- Shared package adder_pkg holds:
  - ADDER_DEFAULT_WIDTH = 4.
  - A function returning the behavioural (width+1)-bit reference sum, for checkers and benches.
- Sub-module full_adder: inputs a, b, ci; outputs s, co; purely combinational; instantiated width times through a generate loop.
- The output register, valid pipeline and optional checker live in ripple_carry_adder itself.

Test Plan (width = 4):
- Exhaustive sweep: a and b each 0..15 with cin = 0, all 256 pairs, in_valid = 1 every cycle.
  - Each result appears one cycle later with {cout, sum} = a + b.
  - out_valid stays high throughout.
- Carry chain with cin: a = 15, b = 15, cin = 1 gives sum = 15, cout = 1. Then a = 15, b = 0, cin = 1 gives sum = 0, cout = 1, exercising the full propagate chain.
- Hold behaviour: apply a = 3, b = 4 with in_valid = 1, then in_valid = 0 with a = 9, b = 9.
  - sum stays 7 and cout stays 0.
  - out_valid drops to 0 one cycle after in_valid falls.
- Asynchronous reset: apply a = 8, b = 8, then assert rst_n low between clk edges.
  - sum = 0, cout = 0 and out_valid = 0 immediately, without waiting for a clock edge.
  - After release, the first in_valid (a = 1, b = 2) yields sum = 3, cout = 0.
- Cross-check: instantiate alongside the lookahead and prefix-tree variants on identical stimulus over the full sweep. Zero mismatches are allowed; with ADDER_SELF_CHECK_EN defined, no error messages may print.
